// File: rtl/seven_segment_scan_decoder.sv
// Reconstructs the packed BCD word from a time-multiplexed, active-low seven-segment bus.
// Optional stall detection is built only when SEVEN_SEG_SCAN_DECODER_TIMEOUT_EN is defined.
module seven_segment_scan_decoder #(
  parameter int unsigned SEGMENT_NUM      = 8,
  parameter int unsigned SEGMENT_NUM_USED = 8,
  parameter int unsigned SETTLE_CYCLES    = 4,
  parameter int unsigned TIMEOUT_CYCLES   = 20000
) (
  input  logic                       i_Clk,
  input  logic                       i_Reset,
  input  logic [6:0]                 i_Segments,
  input  logic [SEGMENT_NUM-1:0]     i_Anodes,
  output logic [4*SEGMENT_NUM-1:0]   o_BCD_Num,
  output logic                       o_Frame_Valid,
  output logic                       o_Glyph_Error,
  output logic                       o_Anode_Error,
  output logic                       o_Stalled
);

  localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int unsigned BCD_W = 4 * SEGMENT_NUM;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETTLE,
    S_CAPTURE,
    S_HOLD
  } state_t;

  // Elaboration-time parameter sanity check
  if (SETTLE_CYCLES == 0 || TIMEOUT_CYCLES == 0 || SEGMENT_NUM_USED > SEGMENT_NUM) begin : g_cfg_check
    $error("seven_segment_scan_decoder: invalid parameter combination");
  end

  logic [6:0]             seg_q;
  logic [6:0]             seg_p;
  logic [SEGMENT_NUM-1:0] an_q;
  logic [SEGMENT_NUM-1:0] an_p;
  logic [SEGMENT_NUM-1:0] an_sel;
  logic [SEGMENT_NUM-1:0] used_mask;
  logic [SEGMENT_NUM-1:0] mask;
  logic [BCD_W-1:0]       shadow;
  logic [SET_W-1:0]       settle_cnt;
  state_t                 state;

  logic       an_changed;
  logic       sample_same;
  logic       an_blank;
  logic       an_onehot;
  logic       an_invalid;
  logic       mask_full;
  logic       settle_done;
  logic       glyph_bad;
  logic [3:0] glyph_digit;

  // Active-low glyph to {error, digit}
  function automatic logic [4:0] decode_glyph(input logic [6:0] seg);
    case (seg)
      7'b1000000: return {1'b0, 4'd0};
      7'b1111001: return {1'b0, 4'd1};
      7'b0100100: return {1'b0, 4'd2};
      7'b0110000: return {1'b0, 4'd3};
      7'b0011001: return {1'b0, 4'd4};
      7'b0010010: return {1'b0, 4'd5};
      7'b0000010: return {1'b0, 4'd6};
      7'b1111000: return {1'b0, 4'd7};
      7'b0000000: return {1'b0, 4'd8};
      7'b0010000: return {1'b0, 4'd9};
      7'b1111111: return {1'b0, 4'hF};
      default:    return {1'b1, 4'hE};
    endcase
  endfunction

  // Classification of the registered sample against the previous one
  always_comb begin
    an_sel      = ~an_q;
    an_changed  = (an_q != an_p);
    sample_same = !an_changed && (seg_q == seg_p);
    an_blank    = (an_sel == '0);
    an_onehot   = !an_blank && ((an_sel & (an_sel - SEGMENT_NUM'(1))) == '0);
    an_invalid  = !an_blank && !an_onehot;
    for (int i = 0; i < int'(SEGMENT_NUM); i++) begin
      used_mask[i] = (i < int'(SEGMENT_NUM_USED));
    end
    mask_full   = ((mask | ~used_mask) == '1);
    settle_done = (state == S_SETTLE) && an_onehot && sample_same &&
                  (settle_cnt >= SET_W'(SETTLE_CYCLES - 1));
    {glyph_bad, glyph_digit} = decode_glyph(seg_q);
  end

  // Input registers, scan FSM, shadow capture and frame publication
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      seg_q         <= '1;
      seg_p         <= '1;
      an_q          <= '1;
      an_p          <= '1;
      state         <= S_IDLE;
      settle_cnt    <= '0;
      mask          <= '0;
      shadow        <= '1;
      o_BCD_Num     <= '1;
      o_Frame_Valid <= 1'b0;
      o_Glyph_Error <= 1'b0;
      o_Anode_Error <= 1'b0;
    end else begin
      seg_q         <= i_Segments;
      seg_p         <= seg_q;
      an_q          <= i_Anodes;
      an_p          <= an_q;
      o_Frame_Valid <= 1'b0;
      o_Glyph_Error <= 1'b0;
      o_Anode_Error <= 1'b0;

      if (!sample_same) begin
        settle_cnt <= '0;
      end else if (settle_cnt != SET_W'(SETTLE_CYCLES)) begin
        settle_cnt <= settle_cnt + SET_W'(1);
      end

      if (an_invalid) begin
        // Pulse once per new bad pattern; a bad bus also kills the partial frame
        o_Anode_Error <= an_changed;
        mask          <= '0;
        state         <= S_IDLE;
      end else begin
        if (mask_full) begin
          o_BCD_Num     <= shadow;
          o_Frame_Valid <= 1'b1;
          mask          <= '0;
        end

        case (state)
          S_IDLE: begin
            if (an_onehot) state <= S_SETTLE;
          end
          S_SETTLE: begin
            if (an_blank) begin
              state <= S_IDLE;
            end else if (settle_done) begin
              state         <= S_CAPTURE;
              o_Glyph_Error <= glyph_bad;
              for (int i = 0; i < int'(SEGMENT_NUM); i++) begin
                if (an_sel[i] && used_mask[i]) begin
                  shadow[4*i +: 4] <= glyph_digit;
                  mask[i]          <= 1'b1;
                end
              end
            end
          end
          S_CAPTURE, S_HOLD: begin
            if (an_changed) begin
              state <= an_blank ? S_IDLE : S_SETTLE;
            end else begin
              state <= S_HOLD;
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

`ifdef SEVEN_SEG_SCAN_DECODER_TIMEOUT_EN
  localparam int unsigned IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [IDLE_W-1:0] idle_cnt;
  logic [IDLE_W-1:0] idle_next;

  // Saturating count of cycles since the last anode change
  always_comb begin
    idle_next = idle_cnt;
    if (an_changed) begin
      idle_next = '0;
    end else if (idle_cnt != IDLE_W'(TIMEOUT_CYCLES)) begin
      idle_next = idle_cnt + IDLE_W'(1);
    end
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      idle_cnt  <= '0;
      o_Stalled <= 1'b0;
    end else begin
      idle_cnt  <= idle_next;
      o_Stalled <= (idle_next == IDLE_W'(TIMEOUT_CYCLES));
    end
  end
`else
  assign o_Stalled = 1'b0;
`endif

endmodule
